// File: rtl/uart_rx_if.sv
// UART receiver signal bundle.
// The line side (rx, s_tick) is driven by the master.
// The received word and its status flags are driven by the receiver (slave).
interface uart_rx_if #(
  parameter int DBIT = 8
);
  logic            rx;
  logic            s_tick;
  logic [DBIT-1:0] dout;
  logic            rx_done_tick;
  logic            parity_err;
  logic            frame_err;

  modport master (
    output rx, s_tick,
    input  dout, rx_done_tick, parity_err, frame_err
  );

  modport slave (
    input  rx, s_tick,
    output dout, rx_done_tick, parity_err, frame_err
  );
endinterface

// File: rtl/uart_rx.sv
// Oversampling UART receiver.
// The line is sampled on a 16x-baud s_tick enable. A start bit is
// qualified at its midpoint, and each data, parity and stop bit is then
// sampled 16 ticks later. One frame is delivered per rx_done_tick, and
// parity and framing status are held until the next frame completes.
module uart_rx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int PAR_EN  = 0,
  parameter int PAR_ODD = 0
) (
  input  logic      clk,
  input  logic      reset,
  uart_rx_if.slave  bus
);

  // The tick counter only needs 4 bits for 16-tick bit cells. It grows
  // to 5 bits so that it can also reach SB_TICK-1 for 1.5 or 2 stop bits.
  localparam int S_W = (SB_TICK > 16) ? 5 : 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t          state_reg, state_next;
  logic [S_W-1:0]  s_reg, s_next;
  logic [2:0]      n_reg, n_next;
  logic [DBIT-1:0] b_reg, b_next;
  logic            par_reg, par_next;
  logic [DBIT-1:0] dout_reg, dout_next;
  logic            done_reg, done_next;
  logic            parity_err_reg, parity_err_next;
  logic            frame_err_reg, frame_err_next;
  logic            rx_meta_reg, rx_s_reg;

  // Two-flop synchronizer. Both flops reset to idle-high, so releasing
  // reset can never look like a falling edge on the line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_reg <= 1'b1;
      rx_s_reg    <= 1'b1;
    end else begin
      rx_meta_reg <= bus.rx;
      rx_s_reg    <= rx_meta_reg;
    end
  end

  // State, counters, shift register and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      s_reg          <= '0;
      n_reg          <= '0;
      b_reg          <= '0;
      par_reg        <= 1'b0;
      dout_reg       <= '0;
      done_reg       <= 1'b0;
      parity_err_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      s_reg          <= s_next;
      n_reg          <= n_next;
      b_reg          <= b_next;
      par_reg        <= par_next;
      dout_reg       <= dout_next;
      done_reg       <= done_next;
      parity_err_reg <= parity_err_next;
      frame_err_reg  <= frame_err_next;
    end
  end

  // Next-state logic. Counters advance only on s_tick. Outputs are
  // computed one clk early so that they register together with the pulse.
  always_comb begin
    state_next      = state_reg;
    s_next          = s_reg;
    n_next          = n_reg;
    b_next          = b_reg;
    par_next        = par_reg;
    done_next       = 1'b0;
    dout_next       = dout_reg;
    parity_err_next = parity_err_reg;
    frame_err_next  = frame_err_reg;

    case (state_reg)
      IDLE: begin
        if (!rx_s_reg) begin
          state_next = START;
          s_next     = '0;
        end
      end

      START: begin
        if (bus.s_tick) begin
          if (s_reg == S_W'(7)) begin
            if (!rx_s_reg) begin
              state_next = DATA;
              s_next     = '0;
              n_next     = '0;
            end else begin
              // The line returned high before mid-start: treat it as noise.
              state_next = IDLE;
            end
          end else begin
            s_next = s_reg + S_W'(1);
          end
        end
      end

      DATA: begin
        if (bus.s_tick) begin
          if (s_reg == S_W'(15)) begin
            s_next = '0;
            b_next = {rx_s_reg, b_reg[DBIT-1:1]};
            if (n_reg == 3'(DBIT - 1)) begin
              state_next = (PAR_EN != 0) ? PARITY : STOP;
            end else begin
              n_next = n_reg + 3'd1;
            end
          end else begin
            s_next = s_reg + S_W'(1);
          end
        end
      end

      PARITY: begin
        if (bus.s_tick) begin
          if (s_reg == S_W'(15)) begin
            par_next   = rx_s_reg;
            s_next     = '0;
            state_next = STOP;
          end else begin
            s_next = s_reg + S_W'(1);
          end
        end
      end

      STOP: begin
        if (bus.s_tick) begin
          if (s_reg == S_W'(SB_TICK - 1)) begin
            // The frame is delivered even when the stop sample is low.
            state_next      = IDLE;
            done_next       = 1'b1;
            dout_next       = b_reg;
            frame_err_next  = ~rx_s_reg;
            parity_err_next = (PAR_EN != 0) ?
                              (((^b_reg) ^ par_reg) != (PAR_ODD != 0)) : 1'b0;
          end else begin
            s_next = s_reg + S_W'(1);
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign bus.dout         = dout_reg;
  assign bus.rx_done_tick = done_reg;
  assign bus.parity_err   = parity_err_reg;
  assign bus.frame_err    = frame_err_reg;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a 125 MHz clock and an s_tick every 68 clk.
// dut0 (no parity) covers the basic, glitch, framing-error and reset
// cases. dut1 (even parity) covers parity checking. dut2 (no parity)
// covers back-to-back frames. The three instances run concurrently.
module tb_uart_rx;

  logic clk = 1'b0;
  always #4 clk = ~clk;

  logic rst_a = 1'b1;
  logic rst_b = 1'b1;

  logic tick     = 1'b0;
  int   tick_div = 0;

  // s_tick generator: one pulse every 68 clk.
  always @(posedge clk) begin
    if (tick_div == 67) begin
      tick_div <= 0;
      tick     <= 1'b1;
    end else begin
      tick_div <= tick_div + 1;
      tick     <= 1'b0;
    end
  end

  uart_rx_if #(.DBIT(8)) if0 ();
  uart_rx_if #(.DBIT(8)) if1 ();
  uart_rx_if #(.DBIT(8)) if2 ();

  assign if0.s_tick = tick;
  assign if1.s_tick = tick;
  assign if2.s_tick = tick;

  uart_rx #(.DBIT(8), .SB_TICK(16), .PAR_EN(0), .PAR_ODD(0))
    dut0 (.clk(clk), .reset(rst_a), .bus(if0));
  uart_rx #(.DBIT(8), .SB_TICK(16), .PAR_EN(1), .PAR_ODD(0))
    dut1 (.clk(clk), .reset(rst_b), .bus(if1));
  uart_rx #(.DBIT(8), .SB_TICK(16), .PAR_EN(0), .PAR_ODD(0))
    dut2 (.clk(clk), .reset(rst_b), .bus(if2));

  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   cnt0  = 0;
  int   cnt1  = 0;
  int   cnt2  = 0;
  int   t2a   = 0;
  int   t2b   = 0;
  logic p0    = 1'b0;
  logic p1    = 1'b0;
  logic p2    = 1'b0;
  logic dbl   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Done-pulse monitor: counts pulses, timestamps dut2 pulses, flags back-to-back pulses.
  always @(negedge clk) begin
    p0 <= if0.rx_done_tick;
    p1 <= if1.rx_done_tick;
    p2 <= if2.rx_done_tick;
    if (if0.rx_done_tick) begin
      cnt0 <= cnt0 + 1;
      if (p0) dbl <= 1'b1;
    end
    if (if1.rx_done_tick) begin
      cnt1 <= cnt1 + 1;
      if (p1) dbl <= 1'b1;
    end
    if (if2.rx_done_tick) begin
      cnt2 <= cnt2 + 1;
      if (p2) dbl <= 1'b1;
      if (cnt2 == 0) t2a <= cyc;
      else           t2b <= cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (tick !== 1'b1) @(posedge clk);
    end
    #1;
  endtask

  task automatic set_rx(input int line, input logic v);
    case (line)
      0:       if0.rx = v;
      1:       if1.rx = v;
      default: if2.rx = v;
    endcase
  endtask

  task automatic send_frame(input int line, input logic [7:0] data, input logic par_en,
                            input logic par_bit, input logic stop_val, input int stop_ticks);
    set_rx(line, 1'b0);
    wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      set_rx(line, data[i]);
      wait_ticks(16);
    end
    if (par_en) begin
      set_rx(line, par_bit);
      wait_ticks(16);
    end
    set_rx(line, stop_val);
    wait_ticks(stop_ticks);
    set_rx(line, 1'b1);
  endtask

  // Watchdog: every wait is tick-bounded, so this only fires if time stalls.
  initial begin
    #700000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    if0.rx = 1'b1;
    if1.rx = 1'b1;
    if2.rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dout",  if0.dout,         32'h0);
    check("rst_done",  if0.rx_done_tick, 32'h0);
    check("rst_perr",  if0.parity_err,   32'h0);
    check("rst_ferr",  if0.frame_err,    32'h0);
    check("rst_dout1", if1.dout,         32'h0);
    rst_a = 1'b0;
    rst_b = 1'b0;
    wait_ticks(4);

    fork
      begin
        // A: good frame 0x55.
        send_frame(0, 8'h55, 1'b0, 1'b0, 1'b1, 16);
        wait_ticks(4);
        check("a_cnt",  cnt0,           32'd1);
        check("a_dout", if0.dout,       32'h55);
        check("a_ferr", if0.frame_err,  32'h0);
        check("a_perr", if0.parity_err, 32'h0);

        // C: 4-tick low glitch while idle must be rejected.
        set_rx(0, 1'b0);
        wait_ticks(4);
        set_rx(0, 1'b1);
        wait_ticks(8);
        check("c_cnt",  cnt0,     32'd1);
        check("c_dout", if0.dout, 32'h55);

        // D: 0x0F with low stop bit. The line stays low past the stop
        // sample, so the receiver re-arms and then rejects it as a glitch.
        send_frame(0, 8'h0F, 1'b0, 1'b0, 1'b0, 12);
        wait_ticks(12);
        check("d_cnt",  cnt0,          32'd2);
        check("d_dout", if0.dout,      32'h0F);
        check("d_ferr", if0.frame_err, 32'h1);
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1, 16);
        wait_ticks(4);
        check("d2_cnt",  cnt0,          32'd3);
        check("d2_dout", if0.dout,      32'h3C);
        check("d2_ferr", if0.frame_err, 32'h0);

        // E: reset in the middle of data bit 4 of 0xFF, then 0x81.
        set_rx(0, 1'b0);
        wait_ticks(16);
        set_rx(0, 1'b1);
        wait_ticks(64);
        wait_ticks(8);
        #1 rst_a = 1'b1;
        #1;
        check("e_async_dout", if0.dout, 32'h0);
        repeat (3) @(posedge clk);
        #1 rst_a = 1'b0;
        check("e_rst_ferr", if0.frame_err, 32'h0);
        wait_ticks(8);
        wait_ticks(48);
        wait_ticks(16);
        wait_ticks(4);
        check("e_cnt_mid", cnt0, 32'd3);
        send_frame(0, 8'h81, 1'b0, 1'b0, 1'b1, 16);
        wait_ticks(4);
        check("e_cnt",  cnt0,          32'd4);
        check("e_dout", if0.dout,      32'h81);
        check("e_ferr", if0.frame_err, 32'h0);
      end

      begin
        // B: even parity, 0xA3 has four ones, so parity bit 0 is correct.
        send_frame(1, 8'hA3, 1'b1, 1'b0, 1'b1, 16);
        wait_ticks(4);
        check("b_cnt",  cnt1,           32'd1);
        check("b_dout", if1.dout,       32'hA3);
        check("b_perr", if1.parity_err, 32'h0);
        check("b_ferr", if1.frame_err,  32'h0);
        send_frame(1, 8'hA3, 1'b1, 1'b1, 1'b1, 16);
        wait_ticks(4);
        check("b2_cnt",  cnt1,           32'd2);
        check("b2_dout", if1.dout,       32'hA3);
        check("b2_perr", if1.parity_err, 32'h1);
        check("b2_ferr", if1.frame_err,  32'h0);
      end

      begin
        // F: 0x00 then 0xFF with no idle gap, completions 160 ticks apart.
        send_frame(2, 8'h00, 1'b0, 1'b0, 1'b1, 16);
        check("f_cnt1",  cnt2,          32'd1);
        check("f_dout0", if2.dout,      32'h00);
        send_frame(2, 8'hFF, 1'b0, 1'b0, 1'b1, 16);
        wait_ticks(4);
        check("f_cnt2",  cnt2,          32'd2);
        check("f_dout1", if2.dout,      32'hFF);
        check("f_ferr",  if2.frame_err, 32'h0);
        check("f_spacing", ((t2b - t2a) >= 10812 && (t2b - t2a) <= 10948), 32'h1);
      end
    join

    check("no_double_pulse", dbl, 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL expose DBIT, default 8, the number of data bits per frame (legal 5..8).
REQ-002 The block SHALL expose SB_TICK, default 16, the number of s_tick pulses in the stop interval (16/24/32 for 1/1.5/2 stop bits).
REQ-003 The block SHALL expose PAR_EN, default 0, where 1 means a parity bit follows the data bits.
REQ-004 The block SHALL expose PAR_ODD, default 0, where 1 selects odd parity and 0 selects even parity.

Ports (name, direction, width, meaning):
REQ-005 The block SHALL have port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-006 The block SHALL have port reset, input, 1, asynchronous and active-high.
REQ-007 The block SHALL have port rx, input, 1, the asynchronous serial line; it idles high.
REQ-008 The block SHALL have port s_tick, input, 1, a one-clk enable pulse at 16x the baud rate, driven by the baud generator.
REQ-009 The block SHALL have port dout, output, DBIT, the last received data word, LSB first on the line.
REQ-010 The block SHALL have port rx_done_tick, output, 1, a one-clk pulse when a frame completes; it is the FIFO write strobe.
REQ-011 The block SHALL have port parity_err, output, 1, valid with rx_done_tick and held until the next completion.
REQ-012 The block SHALL have port frame_err, output, 1, set when the stop sample is 0; valid with rx_done_tick and held until the next completion.

Function
REQ-013 rx SHALL pass through a 2-flop synchronizer, with both flops reset to 1; all later logic SHALL use the synchronized value rx_s only.
REQ-014 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP, with a 4-bit tick counter s, a 3-bit bit counter n and a DBIT shift register b.
REQ-015 In IDLE, when rx_s = 0 the FSM SHALL go to START with s = 0; s_tick is not required for this transition.
REQ-016 In START, on each s_tick s SHALL increment; at the s_tick where s = 7: if rx_s = 0, go to DATA with s = 0 and n = 0; if rx_s = 1 (glitch), return to IDLE with no output pulse.
REQ-017 In DATA, at the s_tick where s = 15, the FSM SHALL set s = 0 and shift b right with rx_s entering the MSB; if n = DBIT-1, go to PARITY when PAR_EN = 1, else to STOP; otherwise n increments.
REQ-018 In PARITY, at the s_tick where s = 15, the FSM SHALL latch the parity sample, set s = 0 and go to STOP.
REQ-019 In STOP, at the s_tick where s = SB_TICK-1, the FSM SHALL sample rx_s, go to IDLE, and pulse rx_done_tick for exactly one clk.
REQ-020 On that same clk, dout SHALL load b, and parity_err and frame_err SHALL update.
REQ-021 parity_err SHALL be (XOR of the data bits XOR the parity sample) != PAR_ODD when PAR_EN = 1, and SHALL be 0 when PAR_EN = 0.
REQ-022 frame_err SHALL be 1 when the stop sample is 0; the frame is still delivered.
REQ-023 Between s_ticks, s, n and the state SHALL hold.
REQ-024 Latency from the end of the stop interval to rx_done_tick SHALL be 1 clk; latency from the rx pin to rx_s SHALL be 2 clk.
REQ-025 If rx_s is still 0 when the FSM returns to IDLE after a frame_err, the FSM SHALL re-enter START immediately; a break produces repeated all-zero frames, each with frame_err = 1.
REQ-026 rx_done_tick SHALL never be high on two consecutive clks.

Reset
REQ-027 Asserting reset at any time, including mid-frame, SHALL force IDLE, s = 0, n = 0, b = 0, dout = 0, rx_done_tick = 0, parity_err = 0, frame_err = 0 and synchronizer flops = 1.
REQ-028 After reset deasserts, a frame already in progress on rx SHALL NOT be delivered unless a new falling edge is seen in IDLE.

Verification
REQ-029 Bench setup SHALL be: clk period 8 ns, s_tick every 68 clk (≈115200 baud), DBIT = 8, SB_TICK = 16, PAR_EN = 0.
REQ-030 Scenario A: send 0x55 with a good stop bit -> one rx_done_tick, dout = 0x55, frame_err = 0, parity_err = 0.
REQ-031 Scenario B: with PAR_EN = 1 and PAR_ODD = 0, send 0xA3 with parity bit 0 -> dout = 0xA3, parity_err = 0; repeat with parity bit 1 -> parity_err = 1.
REQ-032 Scenario C: a low glitch on rx of 4 s_ticks while IDLE -> no rx_done_tick, and the FSM is back in IDLE before the next s = 8.
REQ-033 Scenario D: send 0x0F with the stop bit forced 0 -> rx_done_tick, dout = 0x0F, frame_err = 1; next good frame 0x3C -> frame_err = 0.
REQ-034 Scenario E: assert reset during data bit 4 of 0xFF, release it, then send 0x81 -> the only rx_done_tick carries dout = 0x81.
REQ-035 Scenario F: send 0x00 and 0xFF back-to-back with no idle gap -> two rx_done_ticks separated by 10 bit times ±1 s_tick, dout = 0x00 then 0xFF.
